// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit counter + tagged target predictor with init sweep; BP_GSHARE_EN adds GHR-hashed counter index.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pcF,
    output logic        pred_takenF,
    output logic [31:0] pred_targetF,
    output logic        bp_ready,
    input  logic        upd_validD,
    input  logic [31:0] upd_pcD,
    input  logic        upd_takenD,
    input  logic [31:0] upd_targetD
);
    localparam int N = 1 << IDX_BITS;
    localparam int TL = IDX_BITS + 2;
    localparam int TH = IDX_BITS + TAG_BITS + 1;
    typedef enum logic {INIT, RUN} state_t;
    state_t state_q, state_d;
    logic [IDX_BITS-1:0] sweep_ptr_q, sweep_ptr_d;
    logic                valid_q  [N];
    logic [TAG_BITS-1:0] tag_q    [N];
    logic [1:0]          cnt_q    [N];
    logic [31:0]         target_q [N];
    logic [IDX_BITS-1:0] f_idx, f_cidx, u_idx, u_cidx, v_idx, c_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;
    logic                f_hit, u_hit, upd, v_we, v_val, t_we, c_we;
    logic [1:0]          c_val, u_cnt;
    logic                unused_bits;
    assign unused_bits = ^{pcF[31:TH+1], pcF[1:0], upd_pcD[31:TH+1], upd_pcD[1:0]};
    assign f_idx = pcF[TL-1:2];
    assign f_tag = pcF[TH:TL];
    assign u_idx = upd_pcD[TL-1:2];
    assign u_tag = upd_pcD[TH:TL];
`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_q, ghr_d;
    assign f_cidx = f_idx ^ ghr_q;
    assign u_cidx = u_idx ^ ghr_q;
    assign ghr_d  = upd ? {ghr_q[IDX_BITS-2:0], upd_takenD} : ghr_q;
    always_ff @(posedge clk) ghr_q <= rst_n ? ghr_d : '0;
`else
    assign f_cidx = f_idx;
    assign u_cidx = u_idx;
`endif
    always_comb begin
        bp_ready     = state_q == RUN;
        f_hit        = valid_q[f_idx] && tag_q[f_idx] == f_tag;
        pred_takenF  = bp_ready && f_hit && cnt_q[f_cidx][1];
        pred_targetF = pred_takenF ? target_q[f_idx] : 32'b0;
        upd          = bp_ready && upd_validD;
        u_hit        = valid_q[u_idx] && tag_q[u_idx] == u_tag;
        u_cnt        = cnt_q[u_cidx];
        state_d      = (state_q == INIT && sweep_ptr_q == IDX_BITS'(N - 1)) ? RUN : state_q;
        sweep_ptr_d  = state_q == INIT ? sweep_ptr_q + 1'b1 : sweep_ptr_q;
        // The sweep owns the valid/counter write ports; updates only run once it ends.
        v_we  = !bp_ready || (upd && upd_takenD);
        v_idx = bp_ready ? u_idx : sweep_ptr_q;
        v_val = bp_ready;
        t_we  = upd && upd_takenD;
        c_we  = !bp_ready || (upd && (u_hit || upd_takenD));
        c_idx = bp_ready ? u_cidx : sweep_ptr_q;
        c_val = !bp_ready ? 2'b01 :
                !u_hit ? 2'b10 :
                upd_takenD ? (u_cnt == 2'b11 ? 2'b11 : u_cnt + 2'd1) :
                (u_cnt == 2'b00 ? 2'b00 : u_cnt - 2'd1);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INIT;
            sweep_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n && v_we) valid_q[v_idx] <= v_val;
        if (rst_n && c_we) cnt_q[c_idx] <= c_val;
        if (rst_n && t_we) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_targetD;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: reset/sweep timing, table-driven lookup/update vectors, gshare history when BP_GSHARE_EN.
module tb_branch_predictor;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pcF = '0, upd_pcD = '0, upd_targetD = '0;
    logic        upd_validD = 1'b0, upd_takenD = 1'b0;
    logic        pred_takenF, bp_ready;
    logic [31:0] pred_targetF;
    int checks = 0, errors = 0;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .pcF(pcF), .pred_takenF(pred_takenF),
        .pred_targetF(pred_targetF), .bp_ready(bp_ready), .upd_validD(upd_validD),
        .upd_pcD(upd_pcD), .upd_takenD(upd_takenD), .upd_targetD(upd_targetD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        et;
        logic [31:0] etgt;
    } vec_t;
    typedef struct {
        int          row;
        logic        et;
        logic [31:0] etgt;
    } exp_t;
    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic et, input logic [31:0] etgt);
        vecs.push_back('{pc, uv, upc, ut, utgt, et, etgt});
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic run_vecs();
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            pcF = vecs[i].pc; upd_validD = vecs[i].uv; upd_pcD = vecs[i].upc;
            upd_takenD = vecs[i].ut; upd_targetD = vecs[i].utgt;
            sb.push_back('{i, vecs[i].et, vecs[i].etgt});
            #2;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("row%0d_taken", e.row), {31'b0, pred_takenF}, {31'b0, e.et});
                chk($sformatf("row%0d_target", e.row), pred_targetF, e.etgt);
            end
        end
        @(negedge clk) upd_validD = 1'b0;
        vecs.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        do_reset();
        // Updates are asserted throughout the sweep and must leave no trace.
        for (int i = 0; i < 64; i++) begin
            pcF = (i % 2) ? 32'h100 : 32'(i * 4);
            upd_validD = 1'b1; upd_pcD = 32'h100; upd_takenD = 1'b1; upd_targetD = 32'h200;
            #2;
            chk($sformatf("init_ready_%0d", i), {31'b0, bp_ready}, 0);
            chk($sformatf("init_pred_%0d", i), {31'b0, pred_takenF}, 0);
            chk($sformatf("init_tgt_%0d", i), pred_targetF, 0);
            @(negedge clk);
        end
        upd_validD = 1'b0;
        #2;
        chk("ready_after_64", {31'b0, bp_ready}, 1);
`ifndef BP_GSHARE_EN
        add(32'h100, 0, 0, 0, 0, 0, 0);
        add(32'h104, 1, 32'h100, 1, 32'h200, 0, 0);
        add(32'h100, 0, 0, 0, 0, 1, 32'h200);
        add(32'h104, 0, 0, 0, 0, 0, 0);
        add(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200);
        add(32'h100, 1, 32'h100, 1, 32'h240, 1, 32'h200);
        add(32'h100, 1, 32'h100, 1, 32'h240, 1, 32'h240);
        add(32'h100, 1, 32'h100, 0, 32'h999, 1, 32'h240);
        add(32'h100, 0, 0, 0, 0, 1, 32'h240);
        add(32'h100, 1, 32'h100, 0, 0, 1, 32'h240);
        add(32'h100, 1, 32'h100, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(32'h100, 1, 32'h100, 0, 0, 0, 0);
        add(32'h100, 1, 32'h100, 1, 32'h300, 0, 0);
        add(32'h100, 1, 32'h100, 1, 32'h300, 0, 0);
        add(32'h100, 0, 0, 0, 0, 1, 32'h300);
        add(32'h4100, 1, 32'h4100, 1, 32'h500, 0, 0);
        add(32'h100, 0, 0, 0, 0, 0, 0);
        add(32'h4100, 1, 32'h100, 0, 0, 1, 32'h500);
        add(32'h4100, 0, 0, 0, 0, 1, 32'h500);
        add(32'h100, 1, 32'h100, 1, 32'h600, 0, 0);
        add(32'h100, 0, 0, 0, 0, 1, 32'h600);
        add(32'h4100, 0, 0, 0, 0, 0, 0);
        add(32'h1234, 1, 32'h1234, 1, 32'h2000, 0, 0);
        add(32'h1234, 0, 0, 0, 0, 1, 32'h2000);
        add(32'h100, 0, 0, 0, 0, 1, 32'h600);
        add(32'h2000, 0, 32'h2000, 1, 32'h40, 0, 0);
        add(32'h2000, 0, 0, 0, 0, 0, 0);
        run_vecs();
`endif
        do_reset();
        repeat (20) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        while (!bp_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sweep_restart_cycles", n, 64);
        @(negedge clk) pcF = 32'h100;
        #2;
        chk("cleared_after_sweep", {31'b0, pred_takenF}, 0);
`ifdef BP_GSHARE_EN
        add(32'h2000, 1, 32'h100, 1, 32'h200, 0, 0);
        add(32'h2000, 1, 32'h100, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(32'h2000, 1, 32'h1234, 0, 0, 0, 0);
        add(32'h100, 1, 32'h1234, 1, 32'h2000, 1, 32'h200);
        add(32'h100, 0, 0, 0, 0, 0, 0);
        run_vecs();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
